eth_tx_buf_ctrl: RTL and testbench

// Store-and-forward frame buffer controller for the TX path. Accepts 64-bit AXI-Stream

---
 rtl/eth_tx_buf_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_eth_tx_buf_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_buf_ctrl.sv
// Store-and-forward TX buffer: 64-bit AXIS in -> external RAM -> 16-bit AXIS out.
// Optional feature macro: TX_FRAME_DROP_EN (drop errored / overflowing frames).
module eth_tx_buf_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int LEN_DEPTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [63:0]                  s_tdata_i,
    input  logic [7:0]                   s_tkeep_i,
    input  logic                         s_tlast_i,
    input  logic                         s_tuser_i,
    input  logic                         s_tvalid_i,
    output logic                         s_tready_o,
    output logic [15:0]                  m_tdata_o,
    output logic [1:0]                   m_tkeep_o,
    output logic                         m_tlast_o,
    output logic                         m_tvalid_o,
    input  logic                         m_tready_i,
    output logic                         ram_we_o,
    output logic [ADDR_W-1:0]            ram_waddr_o,
    output logic [63:0]                  ram_wdata_o,
    output logic                         ram_re_o,
    output logic [ADDR_W-1:0]            ram_raddr_o,
    input  logic [63:0]                  ram_rdata_i,
    output logic [$clog2(LEN_DEPTH):0]   frame_cnt_o,
    output logic [15:0]                  drop_cnt_o
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int LF_AW = $clog2(LEN_DEPTH);
    localparam int LF_W  = LF_AW + 1;

    typedef struct packed {
        logic [PTR_W-1:0] words;
        logic [3:0]       last_bytes;
    } len_entry_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_DROP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_LOAD, R_SER} rd_state_t;

    wr_state_t        wr_state, wr_next;
    rd_state_t        rd_state, rd_next;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt, commit_ptr, commit_nxt, rd_ptr, used;
    logic             full, s_ready, discard, beat, push, pop;
    logic [3:0]       keep_cnt, last_bytes;
    len_entry_t       push_entry, lf_head;
    len_entry_t       lf_mem [LEN_DEPTH];
    logic [LF_W-1:0]  lf_wr, lf_rd, lf_cnt;
    logic             lf_full, lf_empty;

    logic [PTR_W-1:0] word_num;
    logic [63:0]      shreg;
    logic [1:0]       lane_idx, lane_last;
    logic             last_word, last_odd, is_last_word_c, lane_end;

    assign used     = wr_ptr - rd_ptr;
    assign full     = (used == PTR_W'(2**ADDR_W));
    assign lf_cnt   = lf_wr - lf_rd;
    assign lf_full  = (lf_cnt == LF_W'(LEN_DEPTH));
    assign lf_empty = (lf_cnt == '0);
    assign lf_head  = lf_mem[lf_rd[LF_AW-1:0]];

    assign keep_cnt   = 4'($countones(s_tkeep_i));
    assign last_bytes = (keep_cnt == 4'd0) ? 4'd1 : keep_cnt;

`ifdef TX_FRAME_DROP_EN
    logic drop;
`endif

    // Write side: acceptance, RAM write strobe and commit are all combinational.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        wr_next    = wr_state;
        wr_ptr_nxt = wr_ptr;
        commit_nxt = commit_ptr;
        s_ready    = 1'b0;
        discard    = 1'b0;
        push       = 1'b0;
`ifdef TX_FRAME_DROP_EN
        drop       = 1'b0;
`endif
        case (wr_state)
            W_IDLE: s_ready = !full && !lf_full;
            W_DATA: begin
`ifdef TX_FRAME_DROP_EN
                s_ready = 1'b1;
                discard = full;
`else
                s_ready = !full;
`endif
            end
            W_DROP: begin
                s_ready = 1'b1;
                discard = 1'b1;
            end
            default: s_ready = 1'b0;
        endcase
        // Ready is held low while reset is asserted so every output reads 0.
        s_ready = s_ready && rst_ni;
        beat    = s_tvalid_i && s_ready;

        if (beat) begin
            if (!discard) wr_ptr_nxt = wr_ptr + PTR_W'(1);
            if (s_tlast_i) begin
                wr_next = W_IDLE;
`ifdef TX_FRAME_DROP_EN
                if (discard || s_tuser_i) begin
                    wr_ptr_nxt = commit_ptr;
                    drop       = 1'b1;
                end else begin
                    push       = 1'b1;
                    commit_nxt = wr_ptr + PTR_W'(1);
                end
`else
                push       = 1'b1;
                commit_nxt = wr_ptr + PTR_W'(1);
`endif
            end else begin
                wr_next = discard ? W_DROP : W_DATA;
            end
        end
    end

    assign push_entry  = '{words: wr_ptr + PTR_W'(1) - commit_ptr, last_bytes: last_bytes};
    assign s_tready_o  = s_ready;
    assign ram_we_o    = beat && !discard;
    assign ram_waddr_o = wr_ptr[ADDR_W-1:0];
    assign ram_wdata_o = s_tdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_state   <= W_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            lf_wr      <= '0;
        end else begin
            wr_state   <= wr_next;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_nxt;
            if (push) lf_wr <= lf_wr + LF_W'(1);
        end
    end

    // NOTE: the length storage is not reset; cleared FIFO pointers make stale entries unreachable.
    always_ff @(posedge clk_i) begin
        if (push) lf_mem[lf_wr[LF_AW-1:0]] <= push_entry;
    end

    // Read side: fetch one word, load it, then serialise 16-bit lanes.
    assign is_last_word_c = (word_num == lf_head.words - PTR_W'(1));
    assign lane_end       = (lane_idx == lane_last);

    always_comb begin
        rd_next  = rd_state;
        ram_re_o = 1'b0;
        pop      = 1'b0;
        case (rd_state)
            R_IDLE:  if (!lf_empty) rd_next = R_FETCH;
            R_FETCH: begin
                ram_re_o = 1'b1;
                rd_next  = R_LOAD;
            end
            R_LOAD:  rd_next = R_SER;
            R_SER: begin
                if (m_tready_i && lane_end) begin
                    if (last_word) begin
                        pop     = 1'b1;
                        rd_next = (lf_cnt > LF_W'(1)) ? R_FETCH : R_IDLE;
                    end else begin
                        rd_next = R_FETCH;
                    end
                end
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_state  <= R_IDLE;
            rd_ptr    <= '0;
            lf_rd     <= '0;
            word_num  <= '0;
            shreg     <= '0;
            lane_idx  <= '0;
            lane_last <= '0;
            last_word <= 1'b0;
            last_odd  <= 1'b0;
        end else begin
            rd_state <= rd_next;
            if (pop) lf_rd <= lf_rd + LF_W'(1);
            case (rd_state)
                R_LOAD: begin
                    shreg     <= ram_rdata_i;
                    lane_idx  <= 2'd0;
                    last_word <= is_last_word_c;
                    last_odd  <= lf_head.last_bytes[0];
                    // The last word carries ceil(last_bytes/2) lanes.
                    lane_last <= is_last_word_c ? 2'((lf_head.last_bytes - 4'd1) >> 1) : 2'd3;
                end
                R_SER: begin
                    if (m_tready_i) begin
                        if (!lane_end) begin
                            shreg    <= {16'h0000, shreg[63:16]};
                            lane_idx <= lane_idx + 2'd1;
                        end else begin
                            rd_ptr   <= rd_ptr + PTR_W'(1);
                            word_num <= last_word ? '0 : word_num + PTR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_tvalid_o  = (rd_state == R_SER);
    assign m_tdata_o   = shreg[15:0];
    assign m_tlast_o   = m_tvalid_o && last_word && lane_end;
    assign m_tkeep_o   = !m_tvalid_o ? 2'b00 : (m_tlast_o && last_odd) ? 2'b01 : 2'b11;
    assign ram_raddr_o = rd_ptr[ADDR_W-1:0];
    assign frame_cnt_o = lf_cnt;

`ifdef TX_FRAME_DROP_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_o <= '0;
        end else if (drop && drop_cnt_o != 16'hFFFF) begin
            drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end
`else
    logic unused_tuser;
    assign unused_tuser = s_tuser_i;
    assign drop_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_eth_tx_buf_ctrl.sv
// Directed bench for eth_tx_buf_ctrl: external RAM model, lane monitor with
// stall-stability tracking, and hand-computed expected lane sequences.
module tb_eth_tx_buf_ctrl;

    localparam int ADDR_W    = 10;
    localparam int LEN_DEPTH = 16;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  k;
        logic        l;
    } lane_t;

    logic                       clk_i, rst_ni;
    logic [63:0]                s_tdata_i;
    logic [7:0]                 s_tkeep_i;
    logic                       s_tlast_i, s_tuser_i, s_tvalid_i, s_tready_o;
    logic [15:0]                m_tdata_o;
    logic [1:0]                 m_tkeep_o;
    logic                       m_tlast_o, m_tvalid_o, m_tready_i;
    logic                       ram_we_o, ram_re_o;
    logic [ADDR_W-1:0]          ram_waddr_o, ram_raddr_o;
    logic [63:0]                ram_wdata_o, ram_rdata_i;
    logic [$clog2(LEN_DEPTH):0] frame_cnt_o;
    logic [15:0]                drop_cnt_o;

    logic rdy_set = 1'b0;
    logic tog_en  = 1'b0;
    logic tog     = 1'b0;
    assign m_tready_i = tog_en ? tog : rdy_set;

    eth_tx_buf_ctrl #(.ADDR_W(ADDR_W), .LEN_DEPTH(LEN_DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_tdata_i(s_tdata_i), .s_tkeep_i(s_tkeep_i), .s_tlast_i(s_tlast_i),
        .s_tuser_i(s_tuser_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
        .m_tdata_o(m_tdata_o), .m_tkeep_o(m_tkeep_o), .m_tlast_o(m_tlast_o),
        .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
        .ram_we_o(ram_we_o), .ram_waddr_o(ram_waddr_o), .ram_wdata_o(ram_wdata_o),
        .ram_re_o(ram_re_o), .ram_raddr_o(ram_raddr_o), .ram_rdata_i(ram_rdata_i),
        .frame_cnt_o(frame_cnt_o), .drop_cnt_o(drop_cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // External RAM with one-cycle read latency.
    logic [63:0] mem [2**ADDR_W];
    always @(posedge clk_i) begin
        if (ram_we_o) mem[ram_waddr_o] <= ram_wdata_o;
        if (ram_re_o) ram_rdata_i <= mem[ram_raddr_o];
    end

    always @(posedge clk_i) begin
        #1;
        if (tog_en) tog = ~tog;
    end

    // Monitor on the falling edge: capture accepted lanes, count reads, track stalls.
    lane_t cap[$];
    int    re_cnt   = 0;
    int    stab_err = 0;
    logic  prev_stall = 1'b0;
    lane_t prev_lane;
    always @(negedge clk_i) begin
        if (ram_re_o) re_cnt++;
        if (!rst_ni) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!m_tvalid_o || {m_tdata_o, m_tkeep_o, m_tlast_o} != prev_lane))
                stab_err++;
            if (m_tvalid_o && m_tready_i) cap.push_back({m_tdata_o, m_tkeep_o, m_tlast_o});
            prev_stall = m_tvalid_o && !m_tready_i;
            prev_lane  = {m_tdata_o, m_tkeep_o, m_tlast_o};
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic lane_t mk(input logic [15:0] d, input logic [1:0] k, input logic l);
        return {d, k, l};
    endfunction

    function automatic logic [63:0] word_pat(input int i);
        return {16'(i), 16'hA5A5 ^ 16'(i), 16'(i * 3), 16'h1000 + 16'(i)};
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        s_tdata_i = d; s_tkeep_i = k; s_tlast_i = l; s_tuser_i = u; s_tvalid_i = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk_i);
            ok = s_tready_o;
            @(posedge clk_i);
            #1;
            n++;
        end
        s_tvalid_i = 1'b0; s_tlast_i = 1'b0; s_tuser_i = 1'b0;
        if (!ok) check("send_timeout", ok, 1);
    endtask

    task automatic wait_lanes(input int target, input int limit);
        int n;
        n = 0;
        while (cap.size() < target && n < limit) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (cap.size() < target) check("lane_timeout", cap.size(), target);
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        settle(2);
        rst_ni = 1'b1;
    endtask

    lane_t exp3 [10];
    lane_t exp7 [7];
    int    base, re_base, st_base, errs;

    initial begin
        rst_ni = 1'b0;
        s_tdata_i = '0; s_tkeep_i = '0; s_tlast_i = 1'b0; s_tuser_i = 1'b0; s_tvalid_i = 1'b0;

        // Reset state
        #1;
        check("rst_tready", s_tready_o, 0);
        check("rst_outputs", {m_tvalid_o, m_tkeep_o, m_tlast_o, ram_we_o, ram_re_o}, 0);
        check("rst_frame_cnt", frame_cnt_o, 0);
        settle(2);
        rst_ni = 1'b1;
        #1;
        check("post_rst_tready", s_tready_o, 1);

        // 3-beat frame, last keep 07, sink always ready -> 10 lanes
        exp3[0] = mk(16'h4444, 2'b11, 1'b0); exp3[1] = mk(16'h3333, 2'b11, 1'b0);
        exp3[2] = mk(16'h2222, 2'b11, 1'b0); exp3[3] = mk(16'h1111, 2'b11, 1'b0);
        exp3[4] = mk(16'h8888, 2'b11, 1'b0); exp3[5] = mk(16'h7777, 2'b11, 1'b0);
        exp3[6] = mk(16'h6666, 2'b11, 1'b0); exp3[7] = mk(16'h5555, 2'b11, 1'b0);
        exp3[8] = mk(16'hDDEE, 2'b11, 1'b0); exp3[9] = mk(16'hCCCC, 2'b01, 1'b1);
        rdy_set = 1'b1;
        base    = cap.size();
        re_base = re_cnt;
        send_beat(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 1'b0);
        send_beat(64'h5555_6666_7777_8888, 8'hFF, 1'b0, 1'b0);
        send_beat(64'hAAAA_BBBB_CCCC_DDEE, 8'h07, 1'b1, 1'b0);
        check("t2_frame_cnt_1", frame_cnt_o, 1);
        wait_lanes(base + 10, 200);
        settle(3);
        check("t2_lane_count", cap.size() - base, 10);
        for (int i = 0; i < 10; i++) check($sformatf("t2_lane%0d", i), cap[base + i], exp3[i]);
        check("t2_ram_re_pulses", re_cnt - re_base, 3);
        check("t2_frame_cnt_0", frame_cnt_o, 0);

        // Same frame with sink ready toggling every cycle
        rdy_set = 1'b0;
        tog_en  = 1'b1;
        base    = cap.size();
        st_base = stab_err;
        send_beat(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 1'b0);
        send_beat(64'h5555_6666_7777_8888, 8'hFF, 1'b0, 1'b0);
        send_beat(64'hAAAA_BBBB_CCCC_DDEE, 8'h07, 1'b1, 1'b0);
        wait_lanes(base + 10, 300);
        tog_en = 1'b0;
        settle(3);
        check("t3_lane_count", cap.size() - base, 10);
        errs = 0;
        for (int i = 0; i < 10; i++) if (cap[base + i] != exp3[i]) errs++;
        check("t3_lane_seq", errs, 0);
        check("t3_stall_stable", stab_err - st_base, 0);

        // Length FIFO full: 16 committed frames block the 17th until one pop
        rdy_set = 1'b0;
        base    = cap.size();
        st_base = stab_err;
        for (int f = 0; f < 16; f++) send_beat({4{16'(f)}}, 8'hFF, 1'b1, 1'b0);
        check("t4_frame_cnt_16", frame_cnt_o, 16);
        s_tdata_i = 64'h0000_0000_0000_BEEF; s_tkeep_i = 8'h01; s_tlast_i = 1'b1; s_tvalid_i = 1'b1;
        settle(3);
        check("t4_blocked_tready", s_tready_o, 0);
        rdy_set = 1'b1;
        wait_lanes(base + 4, 50);
        rdy_set = 1'b0;
        check("t4_after_pop_cnt", frame_cnt_o, 15);
        check("t4_after_pop_tready", s_tready_o, 1);
        send_beat(64'h0000_0000_0000_BEEF, 8'h01, 1'b1, 1'b0);
        check("t4_frame_cnt_16b", frame_cnt_o, 16);
        rdy_set = 1'b1;
        wait_lanes(base + 65, 1000);
        settle(3);
        check("t4_lane_count", cap.size() - base, 65);
        check("t4_frame0_last", cap[base + 3], mk(16'h0000, 2'b11, 1'b1));
        check("t4_frame1_first", cap[base + 4], mk(16'h0001, 2'b11, 1'b0));
        check("t4_frame17_lane", cap[base + 64], mk(16'hBEEF, 2'b01, 1'b1));
        check("t4_drained_cnt", frame_cnt_o, 0);
        check("t4_stall_stable", stab_err - st_base, 0);

        // Errored frame (tuser on tlast) followed by a good frame
        rdy_set = 1'b1;
        base    = cap.size();
        send_beat(64'h9999_9999_9999_9999, 8'hFF, 1'b0, 1'b0);
        send_beat(64'h8888_8888_8888_8888, 8'hFF, 1'b1, 1'b1);
        send_beat(64'h0000_0000_0000_1234, 8'h03, 1'b1, 1'b0);
`ifdef TX_FRAME_DROP_EN
        wait_lanes(base + 1, 200);
        settle(20);
        check("t6_lane_count", cap.size() - base, 1);
        check("t6_good_lane", cap[base], mk(16'h1234, 2'b11, 1'b1));
        check("t6_drop_cnt", drop_cnt_o, 1);
`else
        wait_lanes(base + 9, 200);
        settle(20);
        check("t6_lane_count", cap.size() - base, 9);
        check("t6_bad_first", cap[base], mk(16'h9999, 2'b11, 1'b0));
        check("t6_good_lane", cap[base + 8], mk(16'h1234, 2'b11, 1'b1));
        check("t6_drop_cnt", drop_cnt_o, 0);
`endif
        check("t6_frame_cnt", frame_cnt_o, 0);

        // Fill the whole buffer with one 1024-word frame, then drain and wrap
        apply_reset();
        rdy_set = 1'b0;
        base    = cap.size();
        for (int i = 0; i < 1024; i++) send_beat(word_pat(i), 8'hFF, i == 1023, 1'b0);
        check("t5_full_tready", s_tready_o, 0);
        check("t5_waddr_wrap", ram_waddr_o, 0);
        check("t5_frame_cnt", frame_cnt_o, 1);
        rdy_set = 1'b1;
        wait_lanes(base + 4096, 7000);
        settle(3);
        check("t5_lane_count", cap.size() - base, 4096);
        errs = 0;
        if (cap.size() >= base + 4096) begin
            for (int i = 0; i < 1024; i++) begin
                logic [63:0] w;
                w = word_pat(i);
                for (int l = 0; l < 4; l++)
                    if (cap[base + 4 * i + l] != mk(w[16 * l +: 16], 2'b11, (i == 1023) && (l == 3))) errs++;
            end
        end
        check("t5_drain_data", errs, 0);
        check("t5_drained_cnt", frame_cnt_o, 0);
        check("t5_raddr_wrap", ram_raddr_o, 0);
        check("t5_tready_back", s_tready_o, 1);

        // Reset while both sides are mid-frame, then a clean frame
        rdy_set = 1'b0;
        base    = cap.size();
        send_beat(64'h1111_1111_1111_1111, 8'hFF, 1'b1, 1'b0);
        send_beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0, 1'b0);
        rdy_set = 1'b1;
        wait_lanes(base + 2, 50);
        rst_ni = 1'b0;
        #1;
        check("t7_rst_outputs",
              {m_tvalid_o, m_tkeep_o, m_tlast_o, m_tdata_o, s_tready_o, ram_re_o, ram_we_o}, 0);
        check("t7_rst_frame_cnt", frame_cnt_o, 0);
        settle(2);
        rst_ni = 1'b1;
        exp7[0] = mk(16'hCDEF, 2'b11, 1'b0); exp7[1] = mk(16'h89AB, 2'b11, 1'b0);
        exp7[2] = mk(16'h4567, 2'b11, 1'b0); exp7[3] = mk(16'h0123, 2'b11, 1'b0);
        exp7[4] = mk(16'h3210, 2'b11, 1'b0); exp7[5] = mk(16'h7654, 2'b11, 1'b0);
        exp7[6] = mk(16'hBA98, 2'b11, 1'b1);
        base = cap.size();
        send_beat(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 1'b0);
        send_beat(64'hFEDC_BA98_7654_3210, 8'h3F, 1'b1, 1'b0);
        wait_lanes(base + 7, 200);
        settle(3);
        check("t7_lane_count", cap.size() - base, 7);
        errs = 0;
        if (cap.size() >= base + 7)
            for (int i = 0; i < 7; i++) if (cap[base + i] != exp7[i]) errs++;
        check("t7_lane_seq", errs, 0);
        check("t7_frame_cnt", frame_cnt_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
